// File: rtl/arb_rr_hold.sv
// N-way round-robin arbiter with multi-cycle grant ownership, a hold limit
// enforced only under contention, and a one-cycle zero-grant turnaround between owners.
module arb_rr_hold #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(N),
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      request,
  output logic [N-1:0]      grant,
  output logic              grant_valid,
  output logic [ID_W-1:0]   grant_id,
  output logic              preempt,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [ID_W-1:0]   ptr_q,     ptr_d;
  logic [N-1:0]      grant_q,   grant_d;
  logic              gvalid_q,  gvalid_d;
  logic [ID_W-1:0]   gid_q,     gid_d;
  logic              preempt_q, preempt_d;
  logic [HOLD_W-1:0] hold_q,    hold_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   ptr_after;
  logic              at_limit;
  logic              contended;

  // Circular scan starting at ptr; the first requester encountered wins.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!win_found && request[idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(idx);
      end
    end
  end

  assign ptr_after = (gid_q == ID_W'(N - 1)) ? '0 : gid_q + ID_W'(1);
  assign at_limit  = (hold_q == HOLD_W'(MAX_HOLD));
  assign contended = |(request & ~grant_q);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    gid_d     = gid_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      S_GRANT: begin
        // A voluntary release takes precedence over preemption on the same edge.
        if (!request[gid_q]) begin
          grant_d = '0;
          ptr_d   = ptr_after;
          hold_d  = '0;
          state_d = S_TURN;
        end else if (at_limit && contended) begin
          grant_d   = '0;
          ptr_d     = ptr_after;
          hold_d    = '0;
          preempt_d = 1'b1;
          state_d   = S_TURN;
        end else if (!at_limit) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        // IDLE and TURN both arbitrate; TURN lasts one cycle by construction.
        grant_d = '0;
        hold_d  = '0;
        state_d = S_IDLE;
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          gid_d   = win_idx;
          hold_d  = HOLD_W'(1);
          state_d = S_GRANT;
        end
      end
    endcase
    gvalid_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      gvalid_q  <= 1'b0;
      gid_q     <= '0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      gvalid_q  <= gvalid_d;
      gid_q     <= gid_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = gvalid_q;
  assign grant_id    = gid_q;
  assign preempt     = preempt_q;
  assign hold_cnt    = hold_q;

endmodule

// File: tb/tb_arb_rr_hold.sv
// Bench for arb_rr_hold: directed scenarios plus randomized traffic, checked
// against an owner/pointer reference model and a few hand-derived grant sequences.
module tb_arb_rr_hold;
  localparam int N    = 4;
  localparam int MAXH = 4;
  localparam int IW   = 2;
  localparam int HW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  request = '0;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic          preempt;
  logic [HW-1:0] hold_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the resource, how long, where the scan starts.
  int m_owner, m_ptr, m_last, m_held;
  bit m_pre;

  arb_rr_hold #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .request(request), .grant(grant),
    .grant_valid(grant_valid), .grant_id(grant_id), .preempt(preempt),
    .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_last = 0; m_held = 0; m_pre = 0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] r);
    bit others;
    int i;
    if (m_owner >= 0) begin
      others = 0;
      for (int j = 0; j < N; j++) if (j != m_owner && r[j]) others = 1;
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_held = 0; m_pre = 0;
      end else if (m_held == MAXH && others) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_held = 0; m_pre = 1;
      end else begin
        if (m_held < MAXH) m_held++;
        m_pre = 0;
      end
    end else begin
      m_pre = 0;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (m_owner < 0 && r[i]) begin
          m_owner = i; m_held = 1; m_last = i;
        end
      end
    end
  endfunction

  task automatic check_model(input string tag);
    logic [N-1:0]  eg;
    logic          ev;
    logic [IW-1:0] eid;
    logic [HW-1:0] eh;
    logic          ep;
    eg  = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    ev  = (m_owner >= 0);
    eid = IW'(m_last);
    eh  = HW'(m_held);
    ep  = m_pre;
    checks++;
    assert (grant === eg) else begin
      errors++; $error("FAIL %s grant got %b exp %b", tag, grant, eg);
    end
    checks++;
    assert (grant_valid === ev) else begin
      errors++; $error("FAIL %s grant_valid got %b exp %b", tag, grant_valid, ev);
    end
    checks++;
    assert (grant_id === eid) else begin
      errors++; $error("FAIL %s grant_id got %0d exp %0d", tag, grant_id, eid);
    end
    checks++;
    assert (hold_cnt === eh) else begin
      errors++; $error("FAIL %s hold_cnt got %0d exp %0d", tag, hold_cnt, eh);
    end
    checks++;
    assert (preempt === ep) else begin
      errors++; $error("FAIL %s preempt got %b exp %b", tag, preempt, ep);
    end
  endtask

  task automatic chk_const(input string tag, input logic [N-1:0] eg, input logic ep);
    checks++;
    assert (grant === eg) else begin
      errors++; $error("FAIL %s grant got %b exp %b", tag, grant, eg);
    end
    checks++;
    assert (preempt === ep) else begin
      errors++; $error("FAIL %s preempt got %b exp %b", tag, preempt, ep);
    end
  endtask

  // Called just after a negedge: drive, clock, update model, check at next negedge.
  task automatic step(input logic [N-1:0] r, input string tag);
    request = r;
    checks++;
    assert (!$isunknown(r)) else begin
      errors++; $error("FAIL %s request got %b exp no X/Z", tag, r);
    end
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    logic [N-1:0] seq [21];
    logic [N-1:0] r;
    logic [N-1:0] flip;

    // Reset asserted with all requesters active: nothing may be granted.
    request = 4'b1111;
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_model("reset");
    @(negedge clk);
    rst = 1'b1;

    // Full contention rotates owners, each limited to MAX_HOLD cycles.
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
            4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
            4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
            4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
    for (int i = 0; i < 21; i++) begin
      step(4'b1111, "rotate");
      chk_const("rotate_seq", seq[i], seq[i] == 4'b0000);
    end
    checks++;
    assert (grant_id === 2'd0 && hold_cnt === 3'd1) else begin
      errors++; $error("FAIL first_after_wrap id/hold got %0d/%0d exp 0/1", grant_id, hold_cnt);
    end
    step(4'b0000, "drain");
    step(4'b0000, "idle");

    // Lone requester: hold saturates, never preempted.
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, "solo");
      chk_const("solo_grant", 4'b0100, 1'b0);
    end
    checks++;
    assert (hold_cnt === 3'd4) else begin
      errors++; $error("FAIL solo_sat hold_cnt got %0d exp 4", hold_cnt);
    end
    step(4'b0000, "solo_rel");
    chk_const("solo_rel", 4'b0000, 1'b0);

    // New requests during TURN: scan starts after the previous owner.
    step(4'b0001, "turn_a");
    step(4'b0001, "turn_b");
    step(4'b0000, "turn_rel");
    step(4'b1001, "turn_arb");
    chk_const("turn_win3", 4'b1000, 1'b0);
    step(4'b0001, "turn_rel3");
    step(4'b0001, "turn_win0");
    chk_const("turn_win0", 4'b0001, 1'b0);
    step(4'b0000, "turn_end");

    // Release on the limit edge is a normal release, not a preemption.
    step(4'b0010, "lim_a");
    step(4'b0110, "lim_b");
    step(4'b0110, "lim_c");
    step(4'b0110, "lim_d");
    step(4'b0100, "lim_rel");
    chk_const("lim_rel", 4'b0000, 1'b0);
    step(4'b0100, "lim_next");
    chk_const("lim_next", 4'b0100, 1'b0);
    step(4'b0000, "lim_end");
    step(4'b0000, "lim_idle");

    // Asynchronous reset mid-grant clears outputs before any clock edge.
    step(4'b0010, "ar_a");
    step(4'b0010, "ar_b");
    step(4'b0010, "ar_c");
    chk_const("ar_pre", 4'b0010, 1'b0);
    #2 rst = 1'b0;
    #1 model_reset();
    check_model("async_rst");
    #1 rst = 1'b1;
    step(4'b1010, "ar_after");
    chk_const("ar_after", 4'b0010, 1'b0);

    // Randomized traffic: each request bit toggles with probability 1/4 per cycle.
    r = 4'b1010;
    for (int i = 0; i < 400; i++) begin
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 3) == 0);
      r = r ^ flip;
      step(r, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
